// File: rtl/hv_fault_mgr_if.sv
// rtl/hv_fault_mgr_if.sv - fault manager control/status bundle with host and device modports
interface hv_fault_mgr_if #(
  parameter int ERR_NUM = 8,
  parameter int DBNC_W  = 4,
  parameter int RCVR_W  = 8,
  parameter int RETRY_W = 3
);
  logic               i_pwr_on;
  logic [ERR_NUM-1:0] i_err_raw;
  logic [ERR_NUM-1:0] i_err_mask;
  logic [ERR_NUM-1:0] i_err_kill;
  logic [DBNC_W-1:0]  i_dbnc_th;
  logic [RCVR_W-1:0]  i_rcvr_dly;
  logic [RETRY_W-1:0] i_retry_max;
  logic               i_err_clr;
  logic [ERR_NUM-1:0] o_err_flt;
  logic [ERR_NUM-1:0] o_err_sts;
  logic               o_pwm_en;
  logic               o_intb_n;
  logic [RETRY_W-1:0] o_retry_cnt;
  logic               o_lock;
  logic [2:0]         o_fsm_st;

  modport master (
    output i_pwr_on, i_err_raw, i_err_mask, i_err_kill, i_dbnc_th,
           i_rcvr_dly, i_retry_max, i_err_clr,
    input  o_err_flt, o_err_sts, o_pwm_en, o_intb_n, o_retry_cnt,
           o_lock, o_fsm_st
  );

  modport slave (
    input  i_pwr_on, i_err_raw, i_err_mask, i_err_kill, i_dbnc_th,
           i_rcvr_dly, i_retry_max, i_err_clr,
    output o_err_flt, o_err_sts, o_pwm_en, o_intb_n, o_retry_cnt,
           o_lock, o_fsm_st
  );
endinterface

// File: rtl/hv_fault_mgr.sv
// rtl/hv_fault_mgr.sv - debounced multi-channel HV fault manager; HV_FAULT_LOCK_EN enables retry lock
module hv_fault_mgr #(
  parameter int ERR_NUM = 8,
  parameter int DBNC_W  = 4,
  parameter int RCVR_W  = 8,
  parameter int RETRY_W = 3
) (
  input logic          i_clk,
  input logic          i_rst_n,
  hv_fault_mgr_if.slave bus
);

  typedef enum logic [2:0] {
    PWR_DWN_ST = 3'd0,
    NML_ST     = 3'd1,
    FAULT_ST   = 3'd2,
    RCVR_ST    = 3'd3,
    LOCK_ST    = 3'd4
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [DBNC_W-1:0]  dbnc_cnt [ERR_NUM];
  logic [ERR_NUM-1:0] eff;
  logic [ERR_NUM-1:0] flt;
  logic [ERR_NUM-1:0] sts;
  logic [ERR_NUM-1:0] sts_nxt;
  logic [RCVR_W-1:0]  tmr;
  logic [RETRY_W-1:0] retry_cnt;
  logic               any_flt;
  logic               kill_flt;
  logic               enter_rcvr;
  logic               pwm_en;
  logic               intb_n;
  logic               lock;

  assign eff      = bus.i_err_raw & ~bus.i_err_mask;
  assign any_flt  = |flt;
  assign kill_flt = |(flt & bus.i_err_kill);
  // a fault present in the same cycle as a clear keeps its status bit
  assign sts_nxt  = (sts & ~({ERR_NUM{bus.i_err_clr}} & ~flt)) | flt;

  // per-channel debounce: count while effective, declare fault at threshold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ERR_NUM; i++) dbnc_cnt[i] <= '0;
      flt <= '0;
    end else begin
      for (int i = 0; i < ERR_NUM; i++) begin
        if (!eff[i]) begin
          dbnc_cnt[i] <= '0;
          flt[i]      <= 1'b0;
        end else if (dbnc_cnt[i] >= bus.i_dbnc_th) begin
          flt[i]      <= 1'b1;
        end else begin
          dbnc_cnt[i] <= dbnc_cnt[i] + 1'b1;
        end
      end
    end
  end

  // sticky status register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sts <= '0;
    else          sts <= sts_nxt;
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= PWR_DWN_ST;
    else          state <= nxt;
  end

  // next-state logic; supply loss overrides everything
  always_comb begin
    nxt        = state;
    enter_rcvr = 1'b0;
    if (!bus.i_pwr_on) begin
      nxt = PWR_DWN_ST;
    end else begin
      case (state)
        PWR_DWN_ST: nxt = NML_ST;
        NML_ST:     if (any_flt) nxt = FAULT_ST;
        FAULT_ST: begin
          if (!any_flt) begin
`ifdef HV_FAULT_LOCK_EN
            if (retry_cnt >= bus.i_retry_max) begin
              nxt = LOCK_ST;
            end else begin
              nxt        = RCVR_ST;
              enter_rcvr = 1'b1;
            end
`else
            nxt        = RCVR_ST;
            enter_rcvr = 1'b1;
`endif
          end
        end
        RCVR_ST: begin
          if (any_flt)       nxt = FAULT_ST;
          else if (tmr == '0) nxt = NML_ST;
        end
`ifdef HV_FAULT_LOCK_EN
        LOCK_ST:    if (bus.i_err_clr && !any_flt) nxt = NML_ST;
`endif
        default:    nxt = PWR_DWN_ST;
      endcase
    end
  end

`ifndef HV_FAULT_LOCK_EN
  logic unused_retry_max;
  assign unused_retry_max = ^bus.i_retry_max;
`endif

  // recovery timer: loaded on entry, counts down while waiting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                         tmr <= '0;
    else if (enter_rcvr)                                  tmr <= bus.i_rcvr_dly;
    else if (state == RCVR_ST && nxt == RCVR_ST && tmr != '0) tmr <= tmr - 1'b1;
  end

  // retry counter: clear beats increment, saturates at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      retry_cnt <= '0;
    else if (nxt == PWR_DWN_ST || state == PWR_DWN_ST || bus.i_err_clr)
      retry_cnt <= '0;
    else if (enter_rcvr && retry_cnt != {RETRY_W{1'b1}})
      retry_cnt <= retry_cnt + 1'b1;
  end

  // outputs registered from next state so they line up with o_fsm_st
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_en <= 1'b0;
      intb_n <= 1'b1;
      lock   <= 1'b0;
    end else begin
      pwm_en <= (nxt == NML_ST) || (nxt == FAULT_ST && !kill_flt);
      intb_n <= !((nxt == PWR_DWN_ST) || (nxt == FAULT_ST) ||
                  (nxt == LOCK_ST) || (|sts_nxt));
`ifdef HV_FAULT_LOCK_EN
      lock   <= (nxt == LOCK_ST);
`else
      lock   <= 1'b0;
`endif
    end
  end

  assign bus.o_err_flt   = flt;
  assign bus.o_err_sts   = sts;
  assign bus.o_pwm_en    = pwm_en;
  assign bus.o_intb_n    = intb_n;
  assign bus.o_retry_cnt = retry_cnt;
  assign bus.o_lock      = lock;
  assign bus.o_fsm_st    = state;

endmodule
